// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
//
// Single owner of the BTB write port. Arbitrates between commit-stage branch
// corrections (highest priority, written directly) and ID-stage predictor
// updates (queued in a small FIFO and drained when the port is free). On a
// clr_req pulse it flushes the FIFO and walks every BTB line once, writing
// valid=0, one line per cycle.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   id_valid/id_ready   ID update handshake; id_is_jump, id_pc, id_target payload
//   cm_valid/cm_ready   commit correction handshake; cm_is_jump, cm_pc, cm_target
//   clr_req             pulse: invalidate the whole table
//   clr_busy            sweep in progress
//   clr_done            one-cycle pulse alongside the final sweep write
//   upd_en              registered BTB write enable
//   upd_index           line to write (pc[INDEX_WIDTH+1:2])
//   upd_valid           valid bit to write
//   upd_is_jump         jump flag to write
//   upd_pc, upd_target  PC and target to write (BTB slices the tag itself)
// -----------------------------------------------------------------------------
module btb_update_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter int BTB_SIZE    = 64,
    parameter int INDEX_WIDTH = 6,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic                   id_is_jump,
    input  logic [ADDR_WIDTH-1:0]  id_pc,
    input  logic [ADDR_WIDTH-1:0]  id_target,
    input  logic                   cm_valid,
    output logic                   cm_ready,
    input  logic                   cm_is_jump,
    input  logic [ADDR_WIDTH-1:0]  cm_pc,
    input  logic [ADDR_WIDTH-1:0]  cm_target,
    input  logic                   clr_req,
    output logic                   clr_busy,
    output logic                   clr_done,
    output logic                   upd_en,
    output logic [INDEX_WIDTH-1:0] upd_index,
    output logic                   upd_valid,
    output logic                   upd_is_jump,
    output logic [ADDR_WIDTH-1:0]  upd_pc,
    output logic [ADDR_WIDTH-1:0]  upd_target
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    // Source of the write registered at the next edge.
    typedef enum logic [1:0] {
        WR_NONE,
        WR_COMMIT,
        WR_FIFO,
        WR_CLEAR
    } wr_sel_t;

    typedef struct packed {
        logic                  is_jump;
        logic [ADDR_WIDTH-1:0] pc;
        logic [ADDR_WIDTH-1:0] target;
    } entry_t;

    state_t                 state, next_state;
    wr_sel_t                wr_sel;

    entry_t                 fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [CNT_W-1:0]       count;
    logic                   fifo_empty, fifo_full;
    logic                   push, pop, flush;
    entry_t                 head;

    logic [INDEX_WIDTH-1:0] sweep_idx;
    logic                   sweep_last;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign head       = fifo_mem[rd_ptr];
    assign sweep_last = (sweep_idx == INDEX_WIDTH'(BTB_SIZE - 1));
    assign push       = id_valid && id_ready;

    // ---------------------------------------------------------------- FSM
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clr_req)    next_state = SWEEP;
            SWEEP:   if (sweep_last) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Handshakes and write selection. A commit always wins the port; the FIFO
    // head is drained only when no commit is accepted. A commit to the same PC
    // as the head makes the queued update stale, so the head is dropped.
    // NOTE: every output is given a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        cm_ready = 1'b0;
        id_ready = 1'b0;
        pop      = 1'b0;
        flush    = 1'b0;
        wr_sel   = WR_NONE;
        case (state)
            IDLE: begin
                cm_ready = !clr_req;
                id_ready = !clr_req && !fifo_full;
                if (clr_req) begin
                    flush = 1'b1;
                end else if (cm_valid) begin
                    wr_sel = WR_COMMIT;
                    pop    = !fifo_empty && (head.pc == cm_pc);
                end else if (!fifo_empty) begin
                    wr_sel = WR_FIFO;
                    pop    = 1'b1;
                end
            end
            SWEEP:   wr_sel = WR_CLEAR;
            default: wr_sel = WR_NONE;
        endcase
    end

    // ---------------------------------------------------------------- FIFO
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; entries are only read when the
    // occupancy count says they were written.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= '{is_jump: id_is_jump, pc: id_pc, target: id_target};
    end

    // ---------------------------------------------------------------- sweep
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_idx <= '0;
        end else if (state == SWEEP) begin
            sweep_idx <= sweep_last ? '0 : sweep_idx + 1'b1;
        end else begin
            sweep_idx <= '0;
        end
    end

    // ---------------------------------------------------------------- write port
    // Fields other than upd_en hold when nothing is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_en      <= 1'b0;
            upd_index   <= '0;
            upd_valid   <= 1'b0;
            upd_is_jump <= 1'b0;
            upd_pc      <= '0;
            upd_target  <= '0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            upd_en   <= (wr_sel != WR_NONE);
            // Busy tracks the state being entered, so it drops together with
            // the final write and the done pulse.
            clr_busy <= (next_state == SWEEP);
            clr_done <= (state == SWEEP) && sweep_last;
            case (wr_sel)
                WR_COMMIT: begin
                    upd_index   <= cm_pc[INDEX_WIDTH+1:2];
                    upd_valid   <= 1'b1;
                    upd_is_jump <= cm_is_jump;
                    upd_pc      <= cm_pc;
                    upd_target  <= cm_target;
                end
                WR_FIFO: begin
                    upd_index   <= head.pc[INDEX_WIDTH+1:2];
                    upd_valid   <= 1'b1;
                    upd_is_jump <= head.is_jump;
                    upd_pc      <= head.pc;
                    upd_target  <= head.target;
                end
                WR_CLEAR: begin
                    upd_index   <= sweep_idx;
                    upd_valid   <= 1'b0;
                    upd_is_jump <= 1'b0;
                    upd_pc      <= '0;
                    upd_target  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
